// File: rtl/opb_register_simulink2ppc_latched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | opb_register_simulink2ppc_latched                                          |
// | OPB slave latching a fabric word for PowerPC read-back, with status/ctrl.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module opb_register_simulink2ppc_latched #(
  parameter logic [31:0] C_BASEADDR   = 32'h01204100,
  parameter logic [31:0] C_HIGHADDR   = 32'h012041FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid,
  output logic                    user_data_ack
);

  localparam logic [7:0] C_OFF_DATA   = 8'd0;
  localparam logic [7:0] C_OFF_STATUS = 8'd1;
  localparam logic [7:0] C_OFF_CTRL   = 8'd2;

  logic        r_ack;
  logic        r_rnw;
  logic [7:0]  r_off;
  logic [1:0]  r_wbits;
  logic [31:0] r_rdata;
  logic [31:0] r_data;
  logic        r_new;
  logic        r_overrun;
  logic        r_freeze;
  logic [15:0] r_count;

  logic        w_hit;
  logic        w_start;
  logic [31:0] w_rel;
  logic [7:0]  w_off;
  logic [31:0] w_wdata;
  logic [31:0] w_rdmux;
  logic        w_capture;
  logic        w_data_rd;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_unused;

  // Big-endian bus vectors assign straight across: bus index 0 lands on bit 31.
  assign w_wdata = OPB_DBus;
  assign w_rel   = OPB_ABus - C_BASEADDR;
  assign w_off   = w_rel[9:2];
  assign w_hit   = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_start = w_hit && !r_ack;

  assign w_capture = user_data_valid && !r_freeze;
  assign w_data_rd = r_ack && r_rnw && (r_off == C_OFF_DATA);
  assign w_ctrl_wr = r_ack && !r_rnw && (r_off == C_OFF_CTRL);
  assign w_clear   = w_ctrl_wr && r_wbits[1];

  always_comb begin
    w_rdmux = '0;
    case (w_off)
      C_OFF_DATA:   w_rdmux = r_data;
      C_OFF_STATUS: w_rdmux = {r_count, 13'd0, r_freeze, r_overrun, r_new};
      C_OFF_CTRL:   w_rdmux = {31'd0, r_freeze};
      default:      w_rdmux = '0;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      r_ack     <= 1'b0;
      r_rnw     <= 1'b0;
      r_off     <= '0;
      r_wbits   <= '0;
      r_rdata   <= '0;
      r_data    <= '0;
      r_new     <= 1'b0;
      r_overrun <= 1'b0;
      r_freeze  <= 1'b0;
      r_count   <= '0;
    end else begin
      r_ack <= w_start;
      if (w_start) begin
        r_rnw   <= OPB_RNW;
        r_off   <= w_off;
        r_wbits <= w_wdata[1:0];
        r_rdata <= OPB_RNW ? w_rdmux : 32'd0;
      end

      if (w_capture) begin
        r_data <= user_data_in;
      end

      // A capture coinciding with the DATA read keeps the fresh word flagged.
      if (w_capture) begin
        r_new <= 1'b1;
      end else if (w_data_rd) begin
        r_new <= 1'b0;
      end

      if (w_clear) begin
        r_overrun <= 1'b0;
      end else if (w_capture && r_new && !w_data_rd) begin
        r_overrun <= 1'b1;
      end

      if (w_clear) begin
        r_count <= '0;
      end else if (w_capture) begin
        r_count <= r_count + 16'd1;
      end

      if (w_ctrl_wr) begin
        r_freeze <= r_wbits[0];
      end
    end
  end

  // Outputs are masked by reset so nothing is acknowledged in a reset cycle.
  assign Sl_xferAck    = r_ack && OPB_Rst;
  assign Sl_DBus       = Sl_xferAck ? r_rdata : '0;
  assign user_data_ack = Sl_xferAck && r_rnw && (r_off == C_OFF_DATA);
  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;

  assign w_unused = ^{OPB_BE, OPB_seqAddr, w_rel[31:10], w_rel[1:0], w_wdata[31:2]};

endmodule
`default_nettype wire

// File: tb/tb_opb_register_simulink2ppc_latched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_opb_register_simulink2ppc_latched                                       |
// | Scoreboard bench for the latched fabric-to-PPC OPB register.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_opb_register_simulink2ppc_latched;

  localparam logic [31:0] BASE = 32'h01204100;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic [31:0] user_data_in;
  logic        user_data_valid;
  logic        user_data_ack;

  opb_register_simulink2ppc_latched dut (
    .OPB_Clk        (OPB_Clk),
    .OPB_Rst        (OPB_Rst),
    .OPB_ABus       (OPB_ABus),
    .OPB_BE         (OPB_BE),
    .OPB_DBus       (OPB_DBus),
    .OPB_RNW        (OPB_RNW),
    .OPB_select     (OPB_select),
    .OPB_seqAddr    (OPB_seqAddr),
    .Sl_DBus        (Sl_DBus),
    .Sl_xferAck     (Sl_xferAck),
    .Sl_errAck      (Sl_errAck),
    .Sl_retry       (Sl_retry),
    .Sl_toutSup     (Sl_toutSup),
    .user_data_in   (user_data_in),
    .user_data_valid(user_data_valid),
    .user_data_ack  (user_data_ack)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  typedef struct {
    logic [31:0] data;
    logic        rnw;
    logic        uack;
  } exp_t;

  exp_t sb[$];
  int   ack_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ack_seen = 0;

  always @(posedge OPB_Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every acknowledge pops one scoreboard entry.
  always @(negedge OPB_Clk) begin
    exp_t e;
    total++;
    if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin
      bad++;
      $display("FAIL tied_outs: got %b expected 000", {Sl_errAck, Sl_retry, Sl_toutSup});
    end
    if (Sl_xferAck === 1'b1) begin
      ack_seen++;
      ack_cyc.push_back(cyc);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        if (e.rnw) begin
          total++;
          if (Sl_DBus !== e.data) begin
            bad++;
            $display("FAIL rd_data: got %h expected %h", Sl_DBus, e.data);
          end
        end
        if (user_data_ack !== e.uack) begin
          bad++;
          $display("FAIL user_ack: got %b expected %b", user_data_ack, e.uack);
        end
      end
    end else begin
      total++;
      if (Sl_DBus !== 32'd0 || user_data_ack !== 1'b0) begin
        bad++;
        $display("FAIL idle_outs: got dbus=%h uack=%b expected 0/0", Sl_DBus, user_data_ack);
      end
    end
  end

  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                      input logic [31:0] expv, input logic exp_uack,
                      input logic co_v, input logic [31:0] co_d);
    exp_t e;
    bit   got;
    e.data = expv; e.rnw = rnw; e.uack = exp_uack;
    sb.push_back(e);
    OPB_ABus = addr; OPB_RNW = rnw; OPB_DBus = wdata; OPB_select = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge OPB_Clk); #1;
      if (Sl_xferAck === 1'b1) got = 1'b1;
    end
    OPB_select = 1'b0; OPB_ABus = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout: got no ack for addr %h expected ack", addr);
      void'(sb.pop_back());
    end
    if (got && co_v) begin
      user_data_valid = 1'b1;
      user_data_in = co_d;
    end
    @(posedge OPB_Clk); #1;
    user_data_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] expv);
    xfer(BASE + {24'd0, off}, 1'b1, 32'd0, expv, off == 8'h00, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    xfer(BASE + {24'd0, off}, 1'b0, d, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic strobe(input logic [31:0] d);
    user_data_valid = 1'b1; user_data_in = d;
    @(posedge OPB_Clk); #1;
    user_data_valid = 1'b0;
  endtask

  task automatic no_ack_probe(input string name, input logic [31:0] addr);
    int n0;
    n0 = ack_seen;
    OPB_ABus = addr; OPB_RNW = 1'b1; OPB_select = 1'b1;
    repeat (2) @(posedge OPB_Clk);
    #1;
    OPB_select = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    #1;
    check(name, ack_seen - n0, 0);
  endtask

  initial begin
    int c0;
    int n0;
    exp_t e;
    OPB_Rst = 1'b0; OPB_ABus = '0; OPB_BE = 4'hF; OPB_DBus = '0; OPB_RNW = 1'b0;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; user_data_in = '0; user_data_valid = 1'b0;

    repeat (3) begin
      @(negedge OPB_Clk);
      check("rst_outs", {27'd0, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup, user_data_ack} | Sl_DBus, 32'd0);
    end
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b1;
    @(posedge OPB_Clk); #1;

    rd(8'h04, 32'h0000_0000);
    rd(8'h08, 32'h0000_0000);
    rd(8'h00, 32'h0000_0000);

    // Capture and read
    strobe(32'hDEADBEEF);
    rd(8'h04, 32'h0001_0001);
    rd(8'h00, 32'hDEADBEEF);
    rd(8'h04, 32'h0001_0000);

    // Overrun, then clear
    strobe(32'h1);
    strobe(32'h2);
    rd(8'h04, 32'h0003_0003);
    wr(8'h08, 32'h2);
    rd(8'h04, 32'h0000_0001);
    rd(8'h08, 32'h0000_0000);
    rd(8'h00, 32'h0000_0002);
    rd(8'h04, 32'h0000_0000);

    // Capture in the same cycle as the DATA read ack
    strobe(32'h55);
    xfer(BASE, 1'b1, 32'd0, 32'h55, 1'b1, 1'b1, 32'hAA);
    rd(8'h04, 32'h0002_0001);
    rd(8'h00, 32'h0000_00AA);
    rd(8'h04, 32'h0002_0000);

    // Freeze drops strobes
    wr(8'h08, 32'h1);
    rd(8'h08, 32'h0000_0001);
    strobe(32'h77); strobe(32'h77); strobe(32'h77);
    rd(8'h04, 32'h0002_0004);
    rd(8'h00, 32'h0000_00AA);
    wr(8'h08, 32'h0);
    rd(8'h08, 32'h0000_0000);

    // Unmapped offset and writes to read-only registers
    rd(8'h0C, 32'h0000_0000);
    wr(8'h00, 32'h12345678);
    wr(8'h04, 32'hFFFFFFFF);
    rd(8'h00, 32'h0000_00AA);
    rd(8'h04, 32'h0002_0000);

    no_ack_probe("oor_above", 32'h01204200);
    no_ack_probe("oor_below", 32'h012040FC);

    // Held select: acks only at cycles 1 and 3
    e.data = 32'h0002_0000; e.rnw = 1'b1; e.uack = 1'b0;
    sb.push_back(e); sb.push_back(e);
    ack_cyc.delete();
    c0 = cyc;
    OPB_ABus = BASE + 32'h4; OPB_RNW = 1'b1; OPB_select = 1'b1;
    repeat (4) @(posedge OPB_Clk);
    #1;
    OPB_select = 1'b0;
    repeat (2) @(posedge OPB_Clk);
    #1;
    check("held_ack_count", ack_cyc.size(), 2);
    if (ack_cyc.size() == 2) begin
      check("held_ack0", ack_cyc[0] - c0, 1);
      check("held_ack1", ack_cyc[1] - c0, 3);
    end
    while (sb.size() > ack_cyc.size()) void'(sb.pop_back());

    // Clear together with a capture
    strobe(32'h11);
    xfer(BASE + 32'h8, 1'b0, 32'h2, 32'd0, 1'b0, 1'b1, 32'hBB);
    rd(8'h04, 32'h0000_0001);
    rd(8'h00, 32'h0000_00BB);

    // Reset during the hit cycle
    n0 = ack_seen;
    OPB_ABus = BASE + 32'h4; OPB_RNW = 1'b1; OPB_select = 1'b1; OPB_Rst = 1'b0;
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b0;
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b1;
    repeat (3) @(posedge OPB_Clk);
    #1;
    check("rst_hit_noack", ack_seen - n0, 0);
    rd(8'h04, 32'h0000_0000);
    rd(8'h00, 32'h0000_0000);

    // Count wrap
    user_data_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      user_data_in = i;
      @(posedge OPB_Clk); #1;
    end
    user_data_valid = 1'b0;
    rd(8'h04, 32'hFFFF_0003);
    strobe(32'hCAFEF00D);
    rd(8'h04, 32'h0000_0003);
    rd(8'h00, 32'hCAFEF00D);

    repeat (3) @(posedge OPB_Clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
